// File: rtl/data_island_packet_serializer.sv
// -----------------------------------------------------------------------------
// data_island_packet_serializer
//
// Serializes one 32-pixel HDMI data-island packet onto the 9-bit packet
// channel. Each pixel clock emits one bit group. The group holds one header
// bit and one bit pair from each of the four subpackets. The block also
// generates the BCH(32,24) header parity and the four BCH(64,56) subpacket
// parities on the fly. The generator is G(x)=1+x^6+x^7+x^8, with step
// constant 8'h83.
//
// Ports
//   clk_pixel          in   1    pixel clock, the only clock
//   reset              in   1    synchronous, active-high reset
//   data_island_period in   1    high while the encoder sits in a packet slot
//   header             in   24   HB2:HB1:HB0, with HB0 in [7:0]
//   sub                in   224  subpacket i in sub[56*i +: 56], byte 0 low
//   packet_load        out  1    combinational; inputs are sampled this cycle
//   packet_data        out  9    [0]=header bit, [2i+1]/[2i+2]=even/odd bit
//                                of subpacket i
//   packet_counter     out  5    index of the bit group on packet_data
//   packet_valid       out  1    packet_data carries live packet bits
//
// Handshake: packet_load is the only upstream strobe. The header and sub
// inputs must be valid in any cycle where packet_load is high. The block
// ignores them in every other cycle. Downstream there is no backpressure.
// The outputs packet_data and packet_counter are meaningful only when
// packet_valid is high, and they are zero otherwise.
// -----------------------------------------------------------------------------
module data_island_packet_serializer (
   input  logic         clk_pixel,
   input  logic         reset,
   input  logic         data_island_period,
   input  logic [23:0]  header,
   input  logic [223:0] sub,
   output logic         packet_load,
   output logic [8:0]   packet_data,
   output logic [4:0]   packet_counter,
   output logic         packet_valid
);

   // One LFSR-style BCH step: absorb a single data bit into the parity.
   function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
      return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
   endfunction

   logic [4:0]        cnt_q, cnt_d;
   logic [23:0]       header_q, header_d;
   logic [223:0]      sub_q, sub_d;
   logic [7:0]        ecc_h_q, ecc_h_d;
   logic [3:0][7:0]   ecc_s_q, ecc_s_d;
   logic [8:0]        data_q, data_d;
   logic [4:0]        pcnt_q, pcnt_d;
   logic              valid_q, valid_d;

   // Combinational working values for the current bit group.
   logic              first;
   logic [23:0]       src_header;
   logic [223:0]      src_sub;
   logic [55:0]       sp [4];
   logic [7:0]        ecc_h_cur;
   logic [3:0][7:0]   ecc_s_cur;
   logic              hdr_bit;
   logic [1:0]        sub_bits [4];
   logic [7:0]        ecc_s_mid [4];
   logic [7:0]        ecc_s_nxt [4];
   logic [8:0]        group;

   always_comb begin
      first       = (cnt_q == 5'd0);
      packet_load = data_island_period && first;

      // At index 0 the packet is consumed straight from the inputs. After
      // that it comes only from the shadow copy, so input changes mid-packet
      // have no effect. Parity also seeds from zero here, so a packet never
      // inherits parity state from the packet before it.
      src_header = first ? header : header_q;
      src_sub    = first ? sub    : sub_q;
      ecc_h_cur  = first ? 8'h00  : ecc_h_q;

      // Header bit: data for groups 0..23, then parity bits LSB first. For
      // c in 24..31, c-24 is simply c[2:0].
      if (cnt_q < 5'd24) begin
         hdr_bit = src_header[cnt_q];
         ecc_h_d = bch_step(ecc_h_cur, hdr_bit);
      end else begin
         hdr_bit = ecc_h_cur[cnt_q[2:0]];
         ecc_h_d = ecc_h_cur;
      end

      group    = 9'h000;
      group[0] = hdr_bit;
      ecc_s_d  = '0;
      for (int i = 0; i < 4; i++) begin
         sp[i]        = src_sub[56*i +: 56];
         ecc_s_cur[i] = first ? 8'h00 : ecc_s_q[i];
         // Subpacket pair: data for groups 0..27, then parity pairs. For c in
         // 28..31, c-28 is c[1:0].
         if (cnt_q < 5'd28) begin
            sub_bits[i]  = {sp[i][{cnt_q, 1'b1}], sp[i][{cnt_q, 1'b0}]};
            // The even bit is absorbed before the odd bit, giving two chained
            // steps per cycle.
            ecc_s_mid[i] = bch_step(ecc_s_cur[i], sub_bits[i][0]);
            ecc_s_nxt[i] = bch_step(ecc_s_mid[i], sub_bits[i][1]);
         end else begin
            sub_bits[i]  = {ecc_s_cur[i][{cnt_q[1:0], 1'b1}],
                            ecc_s_cur[i][{cnt_q[1:0], 1'b0}]};
            ecc_s_mid[i] = ecc_s_cur[i];
            ecc_s_nxt[i] = ecc_s_cur[i];
         end
         group[2*i+1] = sub_bits[i][0];
         group[2*i+2] = sub_bits[i][1];
         ecc_s_d[i]   = ecc_s_nxt[i];
      end

      header_d = header_q;
      sub_d    = sub_q;
      if (packet_load) begin
         header_d = header;
         sub_d    = sub;
      end

      if (data_island_period) begin
         cnt_d   = cnt_q + 5'd1;   // wraps 31 -> 0 for back-to-back packets
         data_d  = group;
         pcnt_d  = cnt_q;
         valid_d = 1'b1;
      end else begin
         // Leaving the slot aborts any partial packet for good.
         cnt_d   = 5'd0;
         ecc_h_d = 8'h00;
         ecc_s_d = '0;
         data_d  = 9'h000;
         pcnt_d  = 5'd0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cnt_q    <= 5'd0;
         header_q <= 24'h0;
         sub_q    <= '0;
         ecc_h_q  <= 8'h00;
         ecc_s_q  <= '0;
         data_q   <= 9'h000;
         pcnt_q   <= 5'd0;
         valid_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         header_q <= header_d;
         sub_q    <= sub_d;
         ecc_h_q  <= ecc_h_d;
         ecc_s_q  <= ecc_s_d;
         data_q   <= data_d;
         pcnt_q   <= pcnt_d;
         valid_q  <= valid_d;
      end
   end

   assign packet_data    = data_q;
   assign packet_counter = pcnt_q;
   assign packet_valid   = valid_q;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
module tb_data_island_packet_serializer;

   logic         clk_pixel = 1'b0;
   logic         reset = 1'b1;
   logic         data_island_period = 1'b0;
   logic [23:0]  header = '0;
   logic [223:0] sub = '0;
   logic         packet_load;
   logic [8:0]   packet_data;
   logic [4:0]   packet_counter;
   logic         packet_valid;

   data_island_packet_serializer dut (
      .clk_pixel          (clk_pixel),
      .reset              (reset),
      .data_island_period (data_island_period),
      .header             (header),
      .sub                (sub),
      .packet_load        (packet_load),
      .packet_data        (packet_data),
      .packet_counter     (packet_counter),
      .packet_valid       (packet_valid)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_pixel = ~clk_pixel;

   // ---------------- bookkeeping ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [13:0] exp_q[$];        // {counter, data} per expected valid group
   logic [8:0]  pkt [32];        // expected bit groups of the current packet
   logic [4:0]  m_c = 5'd0;      // bench's own packet index
   bit          hand_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- golden model ----------------
   function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
      return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
   endfunction

   // Builds the packet as bit streams: the header is 24 bits plus 8 parity
   // bits, and each subpacket is 56 bits plus 8 parity bits.
   function automatic void build_packet(input logic [23:0] h, input logic [223:0] s);
      logic [7:0]  eh;
      logic [31:0] hs;
      logic [63:0] ss [4];
      logic [55:0] d;
      logic [7:0]  es;
      eh = 8'h00;
      for (int k = 0; k < 24; k++) eh = bch(eh, h[k]);
      hs = {eh, h};
      for (int i = 0; i < 4; i++) begin
         d  = s[56*i +: 56];
         es = 8'h00;
         for (int k = 0; k < 56; k++) es = bch(es, d[k]);
         ss[i] = {es, d};
      end
      for (int c = 0; c < 32; c++) begin
         pkt[c][0] = hs[c];
         for (int i = 0; i < 4; i++) begin
            pkt[c][2*i+1] = ss[i][2*c];
            pkt[c][2*i+2] = ss[i][2*c+1];
         end
      end
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic per, input logic [23:0] h, input logic [223:0] s);
      @(negedge clk_pixel);
      data_island_period = per;
      header = h;
      sub    = s;
      #1;
      if (per) begin
         chk("packet_load", {31'd0, packet_load}, {31'd0, (m_c == 5'd0)});
         if (m_c == 5'd0 && !hand_mode) build_packet(h, s);
         exp_q.push_back({m_c, pkt[m_c]});
         m_c = m_c + 5'd1;
      end else begin
         chk("packet_load_idle", {31'd0, packet_load}, 32'd0);
         m_c = 5'd0;
      end
   endtask

   task automatic reset_cycle();
      @(negedge clk_pixel);
      reset = 1'b1;
      data_island_period = 1'b1;
      m_c = 5'd0;
      @(posedge clk_pixel);
      #1;
      chk("reset_outputs", {17'd0, packet_valid, packet_counter, packet_data}, 32'd0);
      reset = 1'b0;
   endtask

   function automatic logic [223:0] rand_sub();
      logic [223:0] r;
      for (int k = 0; k < 7; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [13:0] e;
      forever begin
         @(posedge clk_pixel);
         #1;
         if (packet_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got cnt=%0d data=0x%0h expected no output", packet_counter, packet_data);
            end else begin
               e = exp_q.pop_front();
               chk("group", {18'd0, packet_counter, packet_data}, {18'd0, e});
            end
         end else begin
            chk("idle_outputs", {18'd0, packet_counter, packet_data}, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]   hpar;
      logic [223:0] s;
      // reset state
      repeat (2) @(posedge clk_pixel);
      #1;
      chk("reset_state", {17'd0, packet_valid, packet_counter, packet_data}, 32'd0);
      @(negedge clk_pixel);
      reset = 1'b0;
      step(1'b0, 24'h0, '0);

      // 1: all-zero packet, hand vectors
      hand_mode = 1'b1;
      for (int c = 0; c < 32; c++) pkt[c] = 9'h000;
      for (int c = 0; c < 32; c++) step(1'b1, 24'h0, '0);
      step(1'b0, 24'h0, '0);

      // 2: header=1, hand-computed header parity 8'h4A sent LSB first
      hpar = 8'h4A;
      for (int c = 0; c < 32; c++) pkt[c] = 9'h000;
      pkt[0] = 9'h001;
      for (int c = 24; c < 32; c++) pkt[c][0] = hpar[c-24];
      for (int c = 0; c < 32; c++) step(1'b1, 24'h000001, '0);
      step(1'b0, 24'h0, '0);
      hand_mode = 1'b0;

      // 3: single-bit subpackets, back to back, random header
      for (int i = 0; i < 4; i++) begin
         s = '0;
         s[56*i] = 1'b1;
         for (int c = 0; c < 32; c++) step(1'b1, (c == 0) ? 24'($urandom) : 24'h0, s);
      end
      step(1'b0, 24'h0, '0);

      // 3/4: random packets with inputs changing every cycle mid-packet
      for (int p = 0; p < 100; p++)
         for (int c = 0; c < 32; c++) step(1'b1, 24'($urandom), rand_sub());
      step(1'b0, 24'h0, '0);

      // 5: drop the period at c=10 for 3 cycles, then a fresh packet
      for (int c = 0; c < 10; c++) step(1'b1, 24'($urandom), rand_sub());
      repeat (3) step(1'b0, 24'($urandom), rand_sub());
      for (int c = 0; c < 32; c++) step(1'b1, 24'($urandom), rand_sub());

      // 6: reset at c=17 with the period high, then a full packet
      for (int c = 0; c < 17; c++) step(1'b1, 24'($urandom), rand_sub());
      reset_cycle();
      for (int c = 0; c < 32; c++) step(1'b1, 24'($urandom), rand_sub());
      step(1'b0, 24'h0, '0);

      repeat (3) step(1'b0, 24'h0, '0);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
